// File: rtl/readout_seq_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : readout_pkg                                                     |
// | Brief    : Shared types for the readout sequencer (FSM state, counters).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package readout_pkg;

  // Index and sample counters are sized for the widest legal configuration
  localparam int C_CHAN_IDX_W = 5;
  localparam int C_SAMP_CNT_W = 16;

  typedef logic [C_CHAN_IDX_W-1:0] chan_idx_t;
  typedef logic [C_SAMP_CNT_W-1:0] samp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/readout_seq_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : readout_seq_mux_if                                              |
// | Brief    : Channel-FIFO / DAQ-FIFO bundle of the readout sequencer.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface readout_seq_mux_if #(
  parameter int NCHAN  = 16,
  parameter int DATA_W = 12,
  parameter int SAMP_W = 7,
  parameter int NCHIP  = 6
) ();
  localparam int CHIP_W = (NCHIP > 1) ? $clog2(NCHIP) : 1;

  logic                    JTAG_MODE;
  logic                    RD_FIFO;
  logic                    RDY;
  logic [SAMP_W-1:0]       SAMP_MAX;
  logic [NCHAN-1:0]        CHAN_MASK;
  logic [NCHAN*DATA_W-1:0] DIN;
  logic                    OUT_AFULL;
  logic [NCHAN-1:0]        RD_ENA;
  logic                    WREN;
  logic [DATA_W-1:0]       DOUT;
  logic [CHIP_W-1:0]       CHIP;
  logic                    BUSY;
  logic                    DONE;

  modport master (
    input  JTAG_MODE, RD_FIFO, RDY, SAMP_MAX, CHAN_MASK, DIN, OUT_AFULL,
    output RD_ENA, WREN, DOUT, CHIP, BUSY, DONE
  );

  modport slave (
    output JTAG_MODE, RD_FIFO, RDY, SAMP_MAX, CHAN_MASK, DIN, OUT_AFULL,
    input  RD_ENA, WREN, DOUT, CHIP, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/readout_seq_mux_next_chan_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : next_chan_sel                                                   |
// | Brief    : Priority search for the next unmasked channel above cur.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module next_chan_sel
  import readout_pkg::*;
#(
  parameter int NCHAN = 16
) (
  input  logic [NCHAN-1:0] mask,
  input  chan_idx_t        cur,
  input  logic             from_start,
  output chan_idx_t        nxt,
  output logic             last
);

  // Descending scan so the lowest qualifying channel is the one left standing;
  // from_start makes channel 0 eligible and turns last into "all masked".
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (!mask[k] && (from_start || (k > int'(cur)))) begin
        nxt  = chan_idx_t'(k);
        last = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/readout_seq_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : readout_seq_mux                                                 |
// | Brief    : Drains one event per RDY edge from channel FIFOs to DAQ FIFO.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module readout_seq_mux
  import readout_pkg::*;
#(
  parameter int NCHAN  = 16,
  parameter int DATA_W = 12,
  parameter int SAMP_W = 7,
  parameter int NCHIP  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  readout_seq_mux_if.master bus
);
  localparam int CHIP_W = (NCHIP > 1) ? $clog2(NCHIP) : 1;
  localparam logic [CHIP_W-1:0] c_chip_last = CHIP_W'(NCHIP - 1);

  state_t            r_state;
  chan_idx_t         r_chan;
  samp_t             r_samp;
  samp_t             r_samp_max;
  logic [NCHAN-1:0]  r_mask;
  logic              r_armed;
  logic              r_busy;
  logic              r_done;
  logic              r_wren;
  logic [DATA_W-1:0] r_dout;
  logic [CHIP_W-1:0] r_chip;

  chan_idx_t         w_next_chan;
  logic              w_next_last;
  chan_idx_t         w_first_chan;
  logic              w_all_masked;
  logic              w_issue;
  logic              w_trigger;
  logic [NCHAN-1:0]  w_onehot;
  logic [CHIP_W-1:0] w_chip_next;

  next_chan_sel #(.NCHAN(NCHAN)) u_next (
    .mask(r_mask), .cur(r_chan), .from_start(1'b0),
    .nxt(w_next_chan), .last(w_next_last)
  );

  next_chan_sel #(.NCHAN(NCHAN)) u_first (
    .mask(r_mask), .cur('0), .from_start(1'b1),
    .nxt(w_first_chan), .last(w_all_masked)
  );

  assign w_issue     = (r_state == ST_READ) && !bus.OUT_AFULL && !bus.JTAG_MODE;
  assign w_trigger   = (r_state == ST_IDLE) && bus.RDY && r_armed && !bus.JTAG_MODE;
  assign w_onehot    = NCHAN'(1) << r_chan;
  assign w_chip_next = (r_chip == c_chip_last) ? '0 : r_chip + CHIP_W'(1);

  // JTAG owns the read strobes combinationally, ahead of the sequencer
  assign bus.RD_ENA = bus.JTAG_MODE ? {NCHAN{bus.RD_FIFO}}
                                    : (w_issue ? w_onehot : '0);
  assign bus.WREN   = r_wren;
  assign bus.DOUT   = r_dout;
  assign bus.CHIP   = r_chip;
  assign bus.BUSY   = r_busy;
  assign bus.DONE   = r_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_chan     <= '0;
      r_samp     <= '0;
      r_samp_max <= '0;
      r_mask     <= '0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wren     <= 1'b0;
      r_dout     <= '0;
      r_chip     <= '0;
    end else begin
      r_wren <= w_issue;
      r_done <= 1'b0;
      if (w_issue) begin
        r_dout <= bus.DIN[r_chan*DATA_W +: DATA_W];
      end
      // Re-arm only once RDY has dropped, so a level left high never re-fires
      if (!bus.RDY) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state    <= ST_LOAD;
            r_armed    <= 1'b0;
            r_mask     <= bus.CHAN_MASK;
            r_samp_max <= samp_t'(bus.SAMP_MAX[SAMP_W-1:0]);
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.JTAG_MODE) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_chan <= w_first_chan;
            r_samp <= '0;
            if (w_all_masked) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_chip  <= w_chip_next;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (bus.JTAG_MODE) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (!bus.OUT_AFULL) begin
            if (!w_next_last) begin
              r_chan <= w_next_chan;
            end else if (r_samp == r_samp_max) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_chip  <= w_chip_next;
            end else begin
              r_samp <= r_samp + samp_t'(1);
              r_chan <= w_first_chan;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
